riscv_str_ops_ctrl: RTL and testbench



---
 rtl/riscv_str_ops_ctrl.sv | 164 ++++++++++++++++
 tb/tb_riscv_str_ops_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_str_ops_ctrl.sv
// riscv_str_ops_ctrl
// Multi-cycle sequencer for the custom string-operation instructions
// (OPCODE_STR_OPS). A 32-bit operand is walked one byte per cycle through
// a single shared byte-transform lane, stopping at the first NUL byte.
// The packed result is handed to writeback with a valid/ready handshake.
module riscv_str_ops_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [1:0]  operator_i,
  input  logic [31:0] operand_i,
  input  logic        flush_i,
  input  logic        ex_ready_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [2:0]  len_o,
  output logic        nul_o
);

  localparam logic [1:0] STR_OP_UPPER = 2'b00;
  localparam logic [1:0] STR_OP_LOWER = 2'b01;
  localparam logic [1:0] STR_OP_LEET  = 2'b10;
  localparam logic [1:0] STR_OP_ROT13 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] result_q;
  logic [1:0]  op_q;
  logic [1:0]  idx_q;
  logic [2:0]  len_q;
  logic        nul_q;

  logic [7:0]  cur_byte;
  logic [7:0]  xform_byte;
  logic        cur_is_nul;
  logic        last_byte;

  // ROT13 on a single letter: rotate within its own case, mod 26, 8-bit math.
  function automatic logic [7:0] rot13_letter(input logic [7:0] b,
                                              input logic [7:0] base);
    logic [7:0] d;
    d = b - base;
    d = d + 8'd13;
    if (d >= 8'd26) begin
      d = d - 8'd26;
    end
    return base + d;
  endfunction

  // Shared byte-transform lane; bytes outside each operator's set pass through.
  function automatic logic [7:0] xform(input logic [1:0] op,
                                       input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] folded;
    r = b;
    // Folding bit 5 maps 'A'..'Z' onto 'a'..'z'; the LEET targets are all
    // lowercase letters, so only their two case variants can match.
    folded = b | 8'h20;
    case (op)
      STR_OP_UPPER: begin
        if (b >= 8'h61 && b <= 8'h7A) r = b - 8'h20;
      end
      STR_OP_LOWER: begin
        if (b >= 8'h41 && b <= 8'h5A) r = b + 8'h20;
      end
      STR_OP_LEET: begin
        case (folded)
          8'h61:   r = 8'h34; // a
          8'h65:   r = 8'h33; // e
          8'h69:   r = 8'h31; // i
          8'h6F:   r = 8'h30; // o
          8'h73:   r = 8'h35; // s
          8'h74:   r = 8'h37; // t
          default: r = b;
        endcase
      end
      STR_OP_ROT13: begin
        if (b >= 8'h61 && b <= 8'h7A)      r = rot13_letter(b, 8'h61);
        else if (b >= 8'h41 && b <= 8'h5A) r = rot13_letter(b, 8'h41);
      end
      default: r = b;
    endcase
    return r;
  endfunction

  assign cur_byte   = result_q[{idx_q, 3'b000} +: 8];
  assign cur_is_nul = (cur_byte == 8'h00);
  assign last_byte  = (idx_q == 2'd3);
  assign xform_byte = xform(op_q, cur_byte);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable_i) state_d = BUSY;
        BUSY:    if (cur_is_nul || last_byte) state_d = DONE;
        DONE:    if (ex_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Working word, byte index, length and NUL flag; a flush leaves them as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'h0;
      op_q     <= STR_OP_UPPER;
      idx_q    <= 2'd0;
      len_q    <= 3'd0;
      nul_q    <= 1'b0;
    end else if (!flush_i) begin
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            result_q <= operand_i;
            op_q     <= operator_i;
            idx_q    <= 2'd0;
            len_q    <= 3'd0;
            nul_q    <= 1'b0;
          end
        end
        BUSY: begin
          if (cur_is_nul) begin
            // Length already equals idx; remaining bytes are left untouched.
            nul_q <= 1'b1;
          end else begin
            result_q[{idx_q, 3'b000} +: 8] <= xform_byte;
            len_q <= {1'b0, idx_q} + 3'd1;
            if (!last_byte) begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;
  assign len_o    = len_q;
  assign nul_o    = nul_q;

endmodule

// File: tb/tb_riscv_str_ops_ctrl.sv
// Directed self-checking bench for riscv_str_ops_ctrl.
module tb_riscv_str_ops_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable_i;
  logic [1:0]  operator_i;
  logic [31:0] operand_i;
  logic        flush_i;
  logic        ex_ready_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [2:0]  len_o;
  logic        nul_o;

  int checks;
  int errors;

  riscv_str_ops_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable_i),
    .operator_i (operator_i),
    .operand_i  (operand_i),
    .flush_i    (flush_i),
    .ex_ready_i (ex_ready_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .len_o      (len_o),
    .nul_o      (nul_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge after the accept edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] w);
    enable_i   = 1'b1;
    operator_i = op;
    operand_i  = w;
    @(negedge clk);
    enable_i   = 1'b0;
    operand_i  = 32'hDEAD_BEEF;
  endtask

  // Counts edges after the accept edge until valid_o is seen (bounded).
  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, exp_lat);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] w, input logic [31:0] exp_res,
                        input logic [2:0] exp_len, input logic exp_nul,
                        input int exp_lat);
    start_op(op, w);
    chk({tag, "_ready_busy"}, ready_o, 1'b0);
    wait_valid({tag, "_lat"}, exp_lat);
    chk({tag, "_valid"}, valid_o, 1'b1);
    chk({tag, "_result"}, result_o, exp_res);
    chk({tag, "_len"}, len_o, exp_len);
    chk({tag, "_nul"}, nul_o, exp_nul);
    @(negedge clk);
    chk({tag, "_valid_drop"}, valid_o, 1'b0);
    chk({tag, "_ready_back"}, ready_o, 1'b1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    enable_i   = 1'b0;
    operator_i = 2'b00;
    operand_i  = 32'h0;
    flush_i    = 1'b0;
    ex_ready_i = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_ready", ready_o, 1'b1);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_len", len_o, 3'd0);
    chk("rst_nul", nul_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("upper", 2'b00, 32'h6463_6261, 32'h4443_4241, 3'd4, 1'b0, 4);
    run_op("lower_nul", 2'b01, 32'h4142_0041, 32'h4142_0061, 3'd1, 1'b1, 2);
    run_op("zero", 2'b01, 32'h0000_0000, 32'h0000_0000, 3'd0, 1'b1, 1);
    run_op("rot13", 2'b11, 32'h7A21_6948, 32'h6D21_7655, 3'd4, 1'b0, 4);
    run_op("leet", 2'b10, 32'h7473_6574, 32'h3735_3337, 3'd4, 1'b0, 4);
    run_op("upper_bnd", 2'b00, 32'hFF7B_407A, 32'hFF7B_405A, 3'd4, 1'b0, 4);
    run_op("rot13_up", 2'b11, 32'h4D5A_4E41, 32'h5A4D_414E, 3'd4, 1'b0, 4);
    run_op("leet_caps", 2'b10, 32'h4F49_4541, 32'h3031_3334, 3'd4, 1'b0, 4);
    run_op("nul_b3", 2'b00, 32'h0063_6261, 32'h0043_4241, 3'd3, 1'b1, 4);

    // Backpressure with enable_i pulsing while DONE.
    ex_ready_i = 1'b0;
    start_op(2'b00, 32'h6463_6261);
    wait_valid("bp_lat", 4);
    for (int i = 0; i < 3; i++) begin
      enable_i   = 1'b1;
      operator_i = 2'b01;
      operand_i  = 32'h1122_3344;
      @(negedge clk);
      chk("bp_valid", valid_o, 1'b1);
      chk("bp_result", result_o, 32'h4443_4241);
      chk("bp_len", len_o, 3'd4);
      chk("bp_ready", ready_o, 1'b0);
    end
    enable_i   = 1'b0;
    ex_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", ready_o, 1'b1);
    chk("bp_release_valid", valid_o, 1'b0);
    @(negedge clk);
    chk("bp_no_accept", ready_o, 1'b1);

    // Flush at idx 2 in BUSY.
    start_op(2'b00, 32'h6463_6261);
    repeat (2) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy_ready", ready_o, 1'b1);
    chk("flush_busy_valid", valid_o, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("flush_busy_novalid", valid_o, 1'b0);
    end

    // Flush in DONE.
    ex_ready_i = 1'b0;
    start_op(2'b00, 32'h6463_6261);
    wait_valid("flush_done_lat", 4);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    ex_ready_i = 1'b1;
    chk("flush_done_valid", valid_o, 1'b0);
    chk("flush_done_ready", ready_o, 1'b1);

    // Enable together with flush in IDLE is not accepted.
    enable_i = 1'b1;
    flush_i  = 1'b1;
    @(negedge clk);
    enable_i = 1'b0;
    flush_i  = 1'b0;
    chk("en_flush_ready", ready_o, 1'b1);
    @(negedge clk);
    chk("en_flush_valid", valid_o, 1'b0);

    // Asynchronous reset mid-BUSY.
    start_op(2'b00, 32'h6463_6261);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", ready_o, 1'b1);
    chk("arst_valid", valid_o, 1'b0);
    chk("arst_result", result_o, 32'h0);
    chk("arst_len", len_o, 3'd0);
    chk("arst_nul", nul_o, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 2'b00, 32'h6463_6261, 32'h4443_4241, 3'd4, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
